dl_arb_mux: RTL

//   Parameterised N-to-1 arbitrating multiplexer with valid/ready handshake and one registered output stage.

---
 rtl/dl_arb_mux.sv | 101 ++++++++++
 1 files changed

// File: rtl/dl_arb_mux.sv
// dl_arb_mux: N-to-1 arbitrating multiplexer with a valid/ready handshake.
// A round-robin or fixed-priority arbiter picks one valid input. The chosen
// beat goes into a single output register, which can refill in the same
// cycle that it drains.
module dl_arb_mux #(
  parameter int NUM_BITS = 32,
  parameter int NUM_IN   = 3,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = $clog2(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN*NUM_BITS-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_val,
  output logic [NUM_IN-1:0]          in_rdy,
  output logic [NUM_BITS-1:0]        out_data,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [IDX_W-1:0]           out_idx
);

  logic [NUM_BITS-1:0] in_word [NUM_IN];
  logic [NUM_BITS-1:0] out_data_reg;
  logic                out_val_reg;
  logic [IDX_W-1:0]    out_idx_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    ptr_next;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic                load;
  logic                xfer;

  // The stage accepts a beat when it is empty or is draining in this cycle.
  // The load is held off while reset is asserted, so no handshake completes
  // while reset is active.
  assign load = rst_n & (~out_val_reg | out_rdy);
  assign xfer = load & grant_any;

  // Split the packed input bus into words. Each input drives only its own
  // in_rdy bit.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign in_word[gi] = in_data[gi*NUM_BITS +: NUM_BITS];
      assign in_rdy[gi]  = xfer & (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Arbiter: scan NUM_IN slots, starting at ptr (round-robin) or at 0 (fixed),
  // and take the first valid input found.
  always_comb begin
    int start;
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    start     = (ARB_MODE == 1) ? 0 : int'(ptr_reg);
    j         = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = start + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!grant_any && in_val[j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  // Round-robin pointer: move to the slot after the winner, and wrap at NUM_IN-1.
  always_comb begin
    ptr_next = ptr_reg;
    if (ARB_MODE == 0 && xfer) begin
      ptr_next = (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output stage: load the granted beat, or go empty on a drain with no
  // new beat. Otherwise hold the contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg <= '0;
      out_val_reg  <= 1'b0;
      out_idx_reg  <= '0;
    end else if (xfer) begin
      out_data_reg <= in_word[grant_idx];
      out_val_reg  <= 1'b1;
      out_idx_reg  <= grant_idx;
    end else if (load) begin
      out_val_reg  <= 1'b0;
    end
  end

  // Arbitration pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  assign out_data = out_data_reg;
  assign out_val  = out_val_reg;
  assign out_idx  = out_idx_reg;

endmodule
